ray_march_stepper: RTL

RAY_MARCH_STEPPER -- requirements
Module: ray_march_stepper

---
 rtl/ray_march_stepper.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ray_march_stepper.sv
// Sphere-tracing ray marcher: iterates position along a ray, querying an
// external combinational scene-distance stage until it hits a surface,
// exceeds the maximum travel distance, or runs out of query budget.
module ray_march_stepper #(
  parameter int unsigned MAX_STEPS = 64,
  parameter logic [31:0] HIT_EPS   = 32'h0000_0040,
  parameter logic [31:0] MAX_DIST  = 32'h0040_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [95:0] ray_origin,
  input  logic [95:0] ray_dir,
  output logic [95:0] query_pos,
  input  logic [31:0] query_dist,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        result_hit,
  output logic [31:0] result_t,
  output logic [7:0]  result_steps
);

  typedef enum logic [1:0] {
    IDLE,
    QUERY,
    STEP,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [95:0] pos_reg;
  logic [95:0] dir_reg;
  logic [31:0] t_reg;
  logic [31:0] dist_q;
  logic [7:0]  steps;
  logic        hit_reg;

  logic               is_hit;
  logic [8:0]         steps_inc;
  logic               last_step;
  logic signed [32:0] t_sum;
  logic               too_far;

  // Advance one Q16.16 coordinate by dist * dir, keeping product bits [47:16].
  function automatic logic [31:0] step_comp(input logic [31:0] p,
                                            input logic [31:0] d,
                                            input logic [31:0] dc);
    logic signed [63:0] prod;
    prod = $signed(d) * $signed(dc);
    return p + 32'(prod >>> 16);
  endfunction

  // Termination tests on the live scene distance.
  always_comb begin
    is_hit    = $signed(query_dist) < $signed(HIT_EPS);
    steps_inc = {1'b0, steps} + 9'd1;
    last_step = (steps_inc == 9'(MAX_STEPS));
    t_sum     = $signed({t_reg[31], t_reg}) + $signed({query_dist[31], query_dist});
    too_far   = t_sum > $signed({1'b0, MAX_DIST});
  end

  // State register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_valid) state_nxt = QUERY;
      QUERY:   state_nxt = (is_hit || last_step || too_far) ? DONE : STEP;
      STEP:    state_nxt = QUERY;
      DONE:    if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ray datapath: latch on accept, evaluate in QUERY, advance in STEP.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      pos_reg <= '0;
      dir_reg <= '0;
      t_reg   <= '0;
      dist_q  <= '0;
      steps   <= '0;
      hit_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            pos_reg <= ray_origin;
            dir_reg <= ray_dir;
            t_reg   <= '0;
            steps   <= '0;
            hit_reg <= 1'b0;
          end
        end
        QUERY: begin
          dist_q <= query_dist;
          steps  <= steps_inc[7:0];
          if (is_hit)                      hit_reg <= 1'b1;
          else if (last_step || too_far)   hit_reg <= 1'b0;
        end
        STEP: begin
          pos_reg[95:64] <= step_comp(pos_reg[95:64], dist_q, dir_reg[95:64]);
          pos_reg[63:32] <= step_comp(pos_reg[63:32], dist_q, dir_reg[63:32]);
          pos_reg[31:0]  <= step_comp(pos_reg[31:0],  dist_q, dir_reg[31:0]);
          t_reg          <= t_reg + dist_q;
        end
        default: ;
      endcase
    end
  end

  assign start_ready  = (state == IDLE);
  assign result_valid = (state == DONE);
  assign query_pos    = pos_reg;
  assign result_hit   = hit_reg;
  assign result_t     = t_reg;
  assign result_steps = steps;

endmodule
